// File: rtl/fp_pkg.sv
// Shared widths, special encodings and helpers for the pipelined FP adder.
// Unpack and round live here so every stage sees the same encoding rules.
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;
    localparam int SIG_W    = FP_MAN_W + 1;
    localparam int EXT_W    = SIG_W + 3;
    localparam int SUM_W    = FP_MAN_W + 5;
    localparam int EXPS_W   = FP_EXP_W + 2;
    localparam int LZ_W     = $clog2(EXT_W + 1);
    localparam int BIAS     = 2 ** (FP_EXP_W - 1) - 1;

    localparam logic [FP_EXP_W-1:0] EXP_ONES = '1;
    localparam logic [FP_W-1:0] CANON_NAN =
        {1'b0, EXP_ONES, 1'b1, {(FP_MAN_W-1){1'b0}}};
    localparam logic [FP_W-1:0] POS_INF =
        {1'b0, EXP_ONES, {FP_MAN_W{1'b0}}};

    localparam int FLAG_INVALID  = 2;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_INEXACT  = 0;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [SIG_W-1:0]    sig;
        logic                is_zero;
        logic                is_inf;
        logic                is_nan;
    } fp_unp_t;

    typedef struct packed {
        logic [FP_W-1:0] res;
        logic [2:0]      flags;
    } fp_rnd_t;

    typedef struct packed {
        logic                valid;
        logic                forced;
        logic [FP_W-1:0]     forced_res;
        logic [2:0]          forced_flags;
        logic                sign;
        logic                zsign;
        logic                sub;
        logic [FP_EXP_W-1:0] exp;
        logic [SIG_W-1:0]    sig_big;
        logic [SIG_W-1:0]    sig_small;
        logic [FP_EXP_W-1:0] diff;
    } s1_t;

    typedef struct packed {
        logic                valid;
        logic                forced;
        logic [FP_W-1:0]     forced_res;
        logic [2:0]          forced_flags;
        logic                sign;
        logic                zsign;
        logic [FP_EXP_W-1:0] exp;
        logic [SUM_W-1:0]    sum;
    } s2_t;

    // Denormal inputs are flushed to signed zero here.
    function automatic fp_unp_t fp_unpack(input logic [FP_W-1:0] x);
        fp_unp_t             u;
        logic [FP_EXP_W-1:0] e;
        logic [FP_MAN_W-1:0] f;
        e         = x[FP_W-2:FP_MAN_W];
        f         = x[FP_MAN_W-1:0];
        u.sign    = x[FP_W-1];
        u.exp     = e;
        u.is_zero = (e == '0);
        u.is_inf  = (e == EXP_ONES) && (f == '0);
        u.is_nan  = (e == EXP_ONES) && (f != '0);
        u.sig     = u.is_zero ? '0 : {1'b1, f};
        return u;
    endfunction

    function automatic fp_rnd_t fp_round(
        input logic              sign,
        input logic [EXPS_W-1:0] exp,
        input logic [SIG_W-1:0]  mant,
        input logic              g,
        input logic              r,
        input logic              s
    );
        fp_rnd_t           o;
        logic              inc;
        logic [SIG_W:0]    m;
        logic [EXPS_W-1:0] e;
        inc = g & (r | s | mant[0]);
        m   = {1'b0, mant} + {{SIG_W{1'b0}}, inc};
        e   = exp + {{(EXPS_W-1){1'b0}}, m[SIG_W]};
        o.flags = '0;
        if (e >= {2'b00, EXP_ONES}) begin
            o.res                  = {sign, POS_INF[FP_W-2:0]};
            o.flags[FLAG_OVERFLOW] = 1'b1;
            o.flags[FLAG_INEXACT]  = 1'b1;
        end else begin
            o.res = {sign, e[FP_EXP_W-1:0],
                     m[SIG_W] ? m[SIG_W-1:1] : m[SIG_W-2:0]};
            o.flags[FLAG_INEXACT] = g | r | s;
        end
        return o;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input returns WIDTH.
module fp_lzc #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (x_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage FP adder: unpack/compare, align/add, normalise/round/pack.
// One global advance signal moves every stage together.
module fp_add_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [2:0]             out_flags
);

    logic adv;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    logic [TAG_W-1:0] tag1_q, tag2_q;

    logic             valid_d, valid_q;
    logic [FP_W-1:0]  res_d, res_q;
    logic [TAG_W-1:0] tag_d, tag_q;
    logic [2:0]       flags_d, flags_q;

    fp_unp_t ua, ub;
    logic    a_big;

    logic [EXT_W-1:0] ext, mask, small_sh;
    logic [SUM_W-1:0] big_ext;

    logic [LZ_W-1:0]   lz;
    logic [EXT_W-1:0]  norm;
    logic [EXPS_W-1:0] exp_w;
    fp_rnd_t           rnd;

    assign adv        = !valid_q || out_ready;
    assign in_ready   = adv;
    assign out_valid  = valid_q;
    assign out_result = res_q;
    assign out_tag    = tag_q;
    assign out_flags  = flags_q;

    always_comb begin
        ua    = fp_unpack(in_a);
        ub    = fp_unpack(in_b);
        a_big = {ua.exp, ua.sig} >= {ub.exp, ub.sig};
        s1_d           = '0;
        s1_d.valid     = in_valid;
        s1_d.sign      = a_big ? ua.sign : ub.sign;
        s1_d.zsign     = ua.is_zero & ub.is_zero & ua.sign & ub.sign;
        s1_d.sub       = ua.sign ^ ub.sign;
        s1_d.exp       = a_big ? ua.exp : ub.exp;
        s1_d.sig_big   = a_big ? ua.sig : ub.sig;
        s1_d.sig_small = a_big ? ub.sig : ua.sig;
        s1_d.diff      = a_big ? (ua.exp - ub.exp) : (ub.exp - ua.exp);
        priority case (1'b1)
            ua.is_nan || ub.is_nan: begin
                s1_d.forced     = 1'b1;
                s1_d.forced_res = CANON_NAN;
            end
            ua.is_inf && ub.is_inf && s1_d.sub: begin
                s1_d.forced                     = 1'b1;
                s1_d.forced_res                 = CANON_NAN;
                s1_d.forced_flags[FLAG_INVALID] = 1'b1;
            end
            ua.is_inf: begin
                s1_d.forced     = 1'b1;
                s1_d.forced_res = {ua.sign, POS_INF[FP_W-2:0]};
            end
            ub.is_inf: begin
                s1_d.forced     = 1'b1;
                s1_d.forced_res = {ub.sign, POS_INF[FP_W-2:0]};
            end
            default: ;
        endcase
    end

    // Bits shifted past the sticky position are ORed back into it.
    always_comb begin
        ext  = {s1_q.sig_small, 3'b000};
        mask = ~({EXT_W{1'b1}} << s1_q.diff);
        if (s1_q.diff >= FP_EXP_W'(FP_MAN_W + 3)) begin
            small_sh = {{(EXT_W-1){1'b0}}, |s1_q.sig_small};
        end else begin
            small_sh = (ext >> s1_q.diff)
                     | {{(EXT_W-1){1'b0}}, |(ext & mask)};
        end
        big_ext           = {1'b0, s1_q.sig_big, 3'b000};
        s2_d              = '0;
        s2_d.valid        = s1_q.valid;
        s2_d.forced       = s1_q.forced;
        s2_d.forced_res   = s1_q.forced_res;
        s2_d.forced_flags = s1_q.forced_flags;
        s2_d.sign         = s1_q.sign;
        s2_d.zsign        = s1_q.zsign;
        s2_d.exp          = s1_q.exp;
        s2_d.sum          = s1_q.sub ? big_ext - {1'b0, small_sh}
                                     : big_ext + {1'b0, small_sh};
    end

    fp_lzc #(
        .WIDTH (EXT_W),
        .CNT_W (LZ_W)
    ) u_lzc (
        .x_i   (s2_q.sum[EXT_W-1:0]),
        .cnt_o (lz)
    );

    always_comb begin
        norm    = s2_q.sum[EXT_W-1:0] << lz;
        exp_w   = {2'b00, s2_q.exp};
        rnd     = '0;
        res_d   = '0;
        flags_d = '0;
        priority case (1'b1)
            s2_q.forced: begin
                res_d   = s2_q.forced_res;
                flags_d = s2_q.forced_flags;
            end
            s2_q.sum == '0: begin
                res_d = {s2_q.zsign, {(FP_W-1){1'b0}}};
            end
            s2_q.sum[SUM_W-1]: begin
                rnd = fp_round(s2_q.sign, exp_w + EXPS_W'(1),
                               s2_q.sum[SUM_W-1:4], s2_q.sum[3],
                               s2_q.sum[2], |s2_q.sum[1:0]);
                res_d   = rnd.res;
                flags_d = rnd.flags;
            end
            exp_w <= EXPS_W'(lz): begin
                res_d                 = {s2_q.sign, {(FP_W-1){1'b0}}};
                flags_d[FLAG_INEXACT] = 1'b1;
            end
            default: begin
                rnd = fp_round(s2_q.sign, exp_w - EXPS_W'(lz),
                               norm[EXT_W-1:3], norm[2],
                               norm[1], norm[0]);
                res_d   = rnd.res;
                flags_d = rnd.flags;
            end
        endcase
        valid_d = s2_q.valid;
        tag_d   = s2_q.valid ? tag2_q : '0;
        if (!s2_q.valid) begin
            res_d   = '0;
            flags_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            tag1_q  <= '0;
            tag2_q  <= '0;
            valid_q <= 1'b0;
            res_q   <= '0;
            tag_q   <= '0;
            flags_q <= '0;
        end else if (adv) begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            tag1_q  <= in_tag;
            tag2_q  <= tag1_q;
            valid_q <= valid_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
Parametrised, 3-stage pipelined IEEE-754-style floating-point adder. It replaces the same-exponent combinational fraction adder. It fully handles:
- differing exponents and signs
- normalisation
- round-to-nearest-even (RNE)
- zero, infinity and NaN

It sits in the systolic PE datapath behind the multiplier, with valid/ready handshakes on both sides and a passthrough tag for result routing.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored fraction width (hidden bit implicit)
TAG_W, 4, width of sideband tag carried alongside each operation

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  adder can accept operands this cycle
in_a  in  1+EXP_W+MAN_W  operand A {sign, exp, frac}
in_b  in  1+EXP_W+MAN_W  operand B
in_tag  in  TAG_W  sideband, returned unchanged with result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  1+EXP_W+MAN_W  A+B
out_tag  out  TAG_W  tag of this result
out_flags  out  3  {invalid, overflow, inexact}

Behaviour:
- Reset: all stage valid bits clear; out_valid=0, out_result=0, out_tag=0, out_flags=0. in_ready=1 in the cycle after reset deasserts. Reset mid-operation discards all in-flight ops.
- Pipeline advance: adv = !out_valid || out_ready; in_ready = adv (combinational).
  - When adv, every stage register loads from its predecessor, valid bits included.
  - When !adv, all stages hold. No bubble collapsing.
  - Transfer at input when in_valid && in_ready; at output when out_valid && out_ready.
- Latency: exactly 3 cycles from accepted input to out_valid when out_ready is held high. Throughput is 1 per cycle.
- out_* hold stable while out_valid && !out_ready.
- S1, unpack/compare:
  - Flush exp==0 inputs to signed zero (FTZ, no inexact).
  - Detect specials: exp all-ones.
  - Form {1,frac} significands.
  - Swap so the larger magnitude (exp, then frac) is "big"; compute d = exp_big - exp_small.
- S2, align/add:
  - Shift the small significand right by d, with guard, round and sticky bits. d >= MAN_W+3 leaves only sticky (set if small is nonzero).
  - Add if signs are equal, else subtract (big - small, never negative).
  - Sum width is MAN_W+5 including carry.
- S3, normalise/round/pack:
  - Carry-out: shift right 1, exp+1, fold lost bit into sticky.
  - Otherwise: leading-zero count and left shift. Underflow of exponent to <=0 flushes to signed zero; inexact=1 only if the discarded value is nonzero.
  - RNE: increment when G && (R || S || LSB). Mantissa overflow from rounding bumps exp.
  - exp >= all-ones after rounding gives ±Inf with overflow=1 and inexact=1.
  - inexact = G|R|S.
- Specials, resolved in S1 and carried as a forced result:
  - any NaN -> canonical quiet NaN {0, all-ones, 1 followed by zeros}.
  - +Inf + -Inf -> canonical NaN, invalid=1.
  - Inf + finite -> that Inf.
- Zero sign:
  - exact cancellation gives +0.
  - (-0)+(-0) gives -0.
  - (+0)+(-0) gives +0.
- Sign of a nonzero result is the sign of big.
- Tag travels in lockstep with its operation.

Decomposition:
- Package fp_pkg holds:
  - EXP_W/MAN_W-derived localparams: bias, field widths, canonical NaN and Inf patterns.
  - A packed unpacked-float struct {sign, exp, sig, is_zero, is_inf, is_nan}.
  - The flag bit indices.
- One sub-module, fp_lzc: parametrised leading-zero counter used in S3.
- Unpack and round are functions in fp_pkg. Stage registers stay in fp_add_pipe.

Test Plan:
- Basic sums, out_ready=1. Each result appears exactly 3 cycles after acceptance, flags=000.
  - 0x3F800000 + 0x3F800000 -> 0x40000000
  - 0x3FC00000 + 0x40100000 -> 0x40700000
- Cancellation and signed zero:
  - 0x3F800000 + 0xBF800000 -> 0x00000000
  - 0x80000000 + 0x80000000 -> 0x80000000
- Rounding:
  - 0x3F800000 + 0x33800000 (tie) -> 0x3F800000, inexact=1
  - 0x3F800000 + 0x33C00000 -> 0x3F800001, inexact=1
- Specials and overflow:
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000, invalid=1
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1, inexact=1
  - 0x00000001 + 0x3F800000 -> 0x3F800000 (FTZ)
- Backpressure: stream 6 ops with tags 0..5 while out_ready toggles pseudo-randomly.
  - No loss or duplication; tags emerge in order.
  - out_result stable while stalled.
  - in_ready=0 exactly when out_valid && !out_ready.
- Reset mid-stream: assert rst with 3 ops in flight.
  - Next cycle: out_valid=0 and out_result=0.
  - No stale result appears afterwards.
  - The first post-reset op completes in 3 cycles.
